// File: rtl/inv_subbytes_iter.sv
// Iterative inverse SubBytes: LANES bytes per cycle through an inverse S-box.
// Block in and result out use valid/ready handshakes.
module inv_subbytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] blok,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] sb
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SH = 8 * LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 &&
        LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [127:0]   work;
    logic [127:0]   sub;
    logic [127:0]   work_nxt;
    logic           last;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h52;
            8'h01: s = 8'h09;
            8'h02: s = 8'h6a;
            8'h03: s = 8'hd5;
            8'h04: s = 8'h30;
            8'h05: s = 8'h36;
            8'h06: s = 8'ha5;
            8'h07: s = 8'h38;
            8'h08: s = 8'hbf;
            8'h09: s = 8'h40;
            8'h0a: s = 8'ha3;
            8'h0b: s = 8'h9e;
            8'h0c: s = 8'h81;
            8'h0d: s = 8'hf3;
            8'h0e: s = 8'hd7;
            8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c;
            8'h11: s = 8'he3;
            8'h12: s = 8'h39;
            8'h13: s = 8'h82;
            8'h14: s = 8'h9b;
            8'h15: s = 8'h2f;
            8'h16: s = 8'hff;
            8'h17: s = 8'h87;
            8'h18: s = 8'h34;
            8'h19: s = 8'h8e;
            8'h1a: s = 8'h43;
            8'h1b: s = 8'h44;
            8'h1c: s = 8'hc4;
            8'h1d: s = 8'hde;
            8'h1e: s = 8'he9;
            8'h1f: s = 8'hcb;
            8'h20: s = 8'h54;
            8'h21: s = 8'h7b;
            8'h22: s = 8'h94;
            8'h23: s = 8'h32;
            8'h24: s = 8'ha6;
            8'h25: s = 8'hc2;
            8'h26: s = 8'h23;
            8'h27: s = 8'h3d;
            8'h28: s = 8'hee;
            8'h29: s = 8'h4c;
            8'h2a: s = 8'h95;
            8'h2b: s = 8'h0b;
            8'h2c: s = 8'h42;
            8'h2d: s = 8'hfa;
            8'h2e: s = 8'hc3;
            8'h2f: s = 8'h4e;
            8'h30: s = 8'h08;
            8'h31: s = 8'h2e;
            8'h32: s = 8'ha1;
            8'h33: s = 8'h66;
            8'h34: s = 8'h28;
            8'h35: s = 8'hd9;
            8'h36: s = 8'h24;
            8'h37: s = 8'hb2;
            8'h38: s = 8'h76;
            8'h39: s = 8'h5b;
            8'h3a: s = 8'ha2;
            8'h3b: s = 8'h49;
            8'h3c: s = 8'h6d;
            8'h3d: s = 8'h8b;
            8'h3e: s = 8'hd1;
            8'h3f: s = 8'h25;
            8'h40: s = 8'h72;
            8'h41: s = 8'hf8;
            8'h42: s = 8'hf6;
            8'h43: s = 8'h64;
            8'h44: s = 8'h86;
            8'h45: s = 8'h68;
            8'h46: s = 8'h98;
            8'h47: s = 8'h16;
            8'h48: s = 8'hd4;
            8'h49: s = 8'ha4;
            8'h4a: s = 8'h5c;
            8'h4b: s = 8'hcc;
            8'h4c: s = 8'h5d;
            8'h4d: s = 8'h65;
            8'h4e: s = 8'hb6;
            8'h4f: s = 8'h92;
            8'h50: s = 8'h6c;
            8'h51: s = 8'h70;
            8'h52: s = 8'h48;
            8'h53: s = 8'h50;
            8'h54: s = 8'hfd;
            8'h55: s = 8'hed;
            8'h56: s = 8'hb9;
            8'h57: s = 8'hda;
            8'h58: s = 8'h5e;
            8'h59: s = 8'h15;
            8'h5a: s = 8'h46;
            8'h5b: s = 8'h57;
            8'h5c: s = 8'ha7;
            8'h5d: s = 8'h8d;
            8'h5e: s = 8'h9d;
            8'h5f: s = 8'h84;
            8'h60: s = 8'h90;
            8'h61: s = 8'hd8;
            8'h62: s = 8'hab;
            8'h63: s = 8'h00;
            8'h64: s = 8'h8c;
            8'h65: s = 8'hbc;
            8'h66: s = 8'hd3;
            8'h67: s = 8'h0a;
            8'h68: s = 8'hf7;
            8'h69: s = 8'he4;
            8'h6a: s = 8'h58;
            8'h6b: s = 8'h05;
            8'h6c: s = 8'hb8;
            8'h6d: s = 8'hb3;
            8'h6e: s = 8'h45;
            8'h6f: s = 8'h06;
            8'h70: s = 8'hd0;
            8'h71: s = 8'h2c;
            8'h72: s = 8'h1e;
            8'h73: s = 8'h8f;
            8'h74: s = 8'hca;
            8'h75: s = 8'h3f;
            8'h76: s = 8'h0f;
            8'h77: s = 8'h02;
            8'h78: s = 8'hc1;
            8'h79: s = 8'haf;
            8'h7a: s = 8'hbd;
            8'h7b: s = 8'h03;
            8'h7c: s = 8'h01;
            8'h7d: s = 8'h13;
            8'h7e: s = 8'h8a;
            8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a;
            8'h81: s = 8'h91;
            8'h82: s = 8'h11;
            8'h83: s = 8'h41;
            8'h84: s = 8'h4f;
            8'h85: s = 8'h67;
            8'h86: s = 8'hdc;
            8'h87: s = 8'hea;
            8'h88: s = 8'h97;
            8'h89: s = 8'hf2;
            8'h8a: s = 8'hcf;
            8'h8b: s = 8'hce;
            8'h8c: s = 8'hf0;
            8'h8d: s = 8'hb4;
            8'h8e: s = 8'he6;
            8'h8f: s = 8'h73;
            8'h90: s = 8'h96;
            8'h91: s = 8'hac;
            8'h92: s = 8'h74;
            8'h93: s = 8'h22;
            8'h94: s = 8'he7;
            8'h95: s = 8'had;
            8'h96: s = 8'h35;
            8'h97: s = 8'h85;
            8'h98: s = 8'he2;
            8'h99: s = 8'hf9;
            8'h9a: s = 8'h37;
            8'h9b: s = 8'he8;
            8'h9c: s = 8'h1c;
            8'h9d: s = 8'h75;
            8'h9e: s = 8'hdf;
            8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47;
            8'ha1: s = 8'hf1;
            8'ha2: s = 8'h1a;
            8'ha3: s = 8'h71;
            8'ha4: s = 8'h1d;
            8'ha5: s = 8'h29;
            8'ha6: s = 8'hc5;
            8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f;
            8'ha9: s = 8'hb7;
            8'haa: s = 8'h62;
            8'hab: s = 8'h0e;
            8'hac: s = 8'haa;
            8'had: s = 8'h18;
            8'hae: s = 8'hbe;
            8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc;
            8'hb1: s = 8'h56;
            8'hb2: s = 8'h3e;
            8'hb3: s = 8'h4b;
            8'hb4: s = 8'hc6;
            8'hb5: s = 8'hd2;
            8'hb6: s = 8'h79;
            8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a;
            8'hb9: s = 8'hdb;
            8'hba: s = 8'hc0;
            8'hbb: s = 8'hfe;
            8'hbc: s = 8'h78;
            8'hbd: s = 8'hcd;
            8'hbe: s = 8'h5a;
            8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f;
            8'hc1: s = 8'hdd;
            8'hc2: s = 8'ha8;
            8'hc3: s = 8'h33;
            8'hc4: s = 8'h88;
            8'hc5: s = 8'h07;
            8'hc6: s = 8'hc7;
            8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1;
            8'hc9: s = 8'h12;
            8'hca: s = 8'h10;
            8'hcb: s = 8'h59;
            8'hcc: s = 8'h27;
            8'hcd: s = 8'h80;
            8'hce: s = 8'hec;
            8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60;
            8'hd1: s = 8'h51;
            8'hd2: s = 8'h7f;
            8'hd3: s = 8'ha9;
            8'hd4: s = 8'h19;
            8'hd5: s = 8'hb5;
            8'hd6: s = 8'h4a;
            8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d;
            8'hd9: s = 8'he5;
            8'hda: s = 8'h7a;
            8'hdb: s = 8'h9f;
            8'hdc: s = 8'h93;
            8'hdd: s = 8'hc9;
            8'hde: s = 8'h9c;
            8'hdf: s = 8'hef;
            8'he0: s = 8'ha0;
            8'he1: s = 8'he0;
            8'he2: s = 8'h3b;
            8'he3: s = 8'h4d;
            8'he4: s = 8'hae;
            8'he5: s = 8'h2a;
            8'he6: s = 8'hf5;
            8'he7: s = 8'hb0;
            8'he8: s = 8'hc8;
            8'he9: s = 8'heb;
            8'hea: s = 8'hbb;
            8'heb: s = 8'h3c;
            8'hec: s = 8'h83;
            8'hed: s = 8'h53;
            8'hee: s = 8'h99;
            8'hef: s = 8'h61;
            8'hf0: s = 8'h17;
            8'hf1: s = 8'h2b;
            8'hf2: s = 8'h04;
            8'hf3: s = 8'h7e;
            8'hf4: s = 8'hba;
            8'hf5: s = 8'h77;
            8'hf6: s = 8'hd6;
            8'hf7: s = 8'h26;
            8'hf8: s = 8'he1;
            8'hf9: s = 8'h69;
            8'hfa: s = 8'h14;
            8'hfb: s = 8'h63;
            8'hfc: s = 8'h55;
            8'hfd: s = 8'h21;
            8'hfe: s = 8'h0c;
            8'hff: s = 8'h7d;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign last = (cnt == CW'(N - 1));

    // The current group always sits at the MSB end: substitute it there, then
    // rotate left by one group. After N steps every byte is back in place.
    always_comb begin
        sub = work;
        for (int l = 0; l < LANES; l++) begin
            sub[127-8*l -: 8] = inv_sbox(work[127-8*l -: 8]);
        end
        work_nxt = (sub << SH) | (sub >> (128 - SH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = BUSY;
            BUSY: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            sb   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= blok;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    cnt  <= last ? '0 : cnt + 1'b1;
                    if (last) sb <= work_nxt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_subbytes_iter.sv
// Bench for inv_subbytes_iter: five instances (LANES 1..16) share stimulus;
// a monitor scores each against expected blocks queued at issue time.
module tb_inv_subbytes_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] blok;
    logic         out_ready;
    logic [4:0]   ir;
    logic [4:0]   ov;
    logic [127:0] sbv [5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int or_mode = 0;

    logic [127:0] exp_q[$];
    int rd [5];
    int acc [5];
    int rise [5];
    bit prev [5];
    bit want [5];

    logic [7:0] fwd_t [256];

    for (genvar g = 0; g < 5; g++) begin : gd
        inv_subbytes_iter #(.LANES(1 << g)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid),
            .in_ready(ir[g]),
            .blok(blok),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .sb(sbv[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input bit ok, input string nm, input int lanes,
                       input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s lanes=%0d got=%h want=%h", nm, lanes, got, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic hi;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            fwd_t[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3)
                     ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] fwd_sub(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fwd_t[v[127-8*i -: 8]];
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (!rst_n) begin
                chk(ov[i] == 1'b0, "rst_out_valid", 1 << i, 128'(ov[i]), 128'd0);
                chk(ir[i] == 1'b1, "rst_in_ready", 1 << i, 128'(ir[i]), 128'd1);
                chk(sbv[i] == 128'd0, "rst_sb", 1 << i, sbv[i], 128'd0);
                rd[i] = exp_q.size();
                prev[i] = 1'b0;
                want[i] = 1'b0;
            end else begin
                chk(!(ov[i] && ir[i]), "excl", 1 << i, 128'({ov[i], ir[i]}), 128'd2);
                if (want[i]) chk(ir[i] == 1'b1, "ready_after", 1 << i, 128'(ir[i]), 128'd1);
                want[i] = 1'b0;
                if (ov[i]) begin
                    if (rd[i] >= exp_q.size())
                        chk(1'b0, "spurious", 1 << i, sbv[i], 128'd0);
                    else
                        chk(sbv[i] == exp_q[rd[i]], "sb", 1 << i, sbv[i], exp_q[rd[i]]);
                    if (!prev[i]) begin
                        rise[i]++;
                        chk(cyc == acc[i] + (16 >> i), "latency", 1 << i,
                            128'(cyc - acc[i]), 128'(16 >> i));
                    end
                    if (out_ready) begin
                        rd[i]++;
                        want[i] = 1'b1;
                    end
                end
                if (in_valid && ir[i]) acc[i] = cyc + 1;
                prev[i] = ov[i];
            end
        end
    end

    task automatic issue(input logic [127:0] b, input logic [127:0] e);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (ir == 5'h1f) ok = 1'b1;
        end
        if (!ok) begin
            chk(1'b0, "issue_timeout", 0, 128'(ir), 128'h1f);
        end else begin
            in_valid = 1'b1;
            blok = b;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    function automatic bit all_drained();
        for (int i = 0; i < 5; i++) if (rd[i] != exp_q.size()) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (all_drained()) ok = 1'b1;
        end
        if (!ok) chk(1'b0, "drain_timeout", 0, 128'(rd[0]), 128'(exp_q.size()));
    endtask

    logic [127:0] r;
    int r0;

    initial begin
        in_valid = 1'b0;
        blok = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd[i] = 0; acc[i] = 0; rise[i] = 0; prev[i] = 0; want[i] = 0;
        end
        build_sbox();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk(ir == 5'h1f, "idle_in_ready", 0, 128'(ir), 128'h1f);
            chk(ov == 5'h00, "idle_out_valid", 0, 128'(ov), 128'h0);
        end
        for (int i = 0; i < 5; i++) chk(sbv[i] == 128'd0, "idle_sb", 1 << i, sbv[i], 128'd0);

        issue(128'h637c777bf26b6fc53001672bfed7ab76,
              128'h000102030405060708090a0b0c0d0e0f);
        drain();

        or_mode = 2;
        issue({16{8'h52}}, {16{8'h48}});
        for (int t = 0; t < 100 && ov != 5'h1f; t++) @(negedge clk);
        chk(ov == 5'h1f, "bp_all_done", 0, 128'(ov), 128'h1f);
        repeat (7) @(posedge clk);
        or_mode = 0;
        drain();

        issue({16'h16ed, 104'h0, 8'h63}, {16'hff53, {13{8'h52}}, 8'h00});
        drain();

        r0 = rise[2];
        r = {$urandom, $urandom, $urandom, $urandom};
        issue(fwd_sub(r), r);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk(rise[2] == r0, "abort_no_pulse", 4, 128'(rise[2]), 128'(r0));
        r = {$urandom, $urandom, $urandom, $urandom};
        issue(fwd_sub(r), r);
        drain();

        or_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            issue(fwd_sub(r), r);
        end
        drain();
        or_mode = 0;

        for (int i = 0; i < 5; i++)
            chk(rd[i] == exp_q.size(), "count", 1 << i, 128'(rd[i]), 128'(exp_q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
